wb_store_commit_q: RTL and testbench

Parametrised next-generation writeback commit block. It accepts one retiring instruction per cycle carrying NUM_CH result channels. Register and segment writes commit immediately. Memory-destination results go into an internal DEPTH-entry store queue, which drains to the memory write port through a valid/ready handshake. Exceptions and interrupts are sequenced by an FSM that drains outstanding stores before the event is signalled to fetch.

---
 rtl/wb_pkg.sv | 40 ++++
 rtl/wbq_fifo.sv | 153 +++++++++++++++
 rtl/wb_store_commit_q.sv | 156 +++++++++++++++
 tb/tb_wb_store_commit_q.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types for the writeback commit block and its store queue.
//   - wb_state_e : exception/interrupt sequencing states
//   - ie_type_e  : exception type encodings carried in final_ie_type[2:0]
//   - IE_IRQ_BIT : bit of final_ie_type that flags an external interrupt
//   - popcount32 : population count of a channel-flag vector
// -----------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SIGNAL = 2'd2
    } wb_state_e;

    typedef enum logic [2:0] {
        IE_DIV0    = 3'd0,
        IE_DEBUG   = 3'd1,
        IE_NMI     = 3'd2,
        IE_BRKPT   = 3'd3,
        IE_OVF     = 3'd4,
        IE_BOUND   = 3'd5,
        IE_BADOP   = 3'd6,
        IE_NOFPU   = 3'd7
    } ie_type_e;

    localparam int IE_IRQ_BIT = 3;

    // Counts set bits; callers zero-extend narrower flag vectors.
    function automatic logic [7:0] popcount32(input logic [31:0] vec);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {7'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/wbq_fifo.sv
// -----------------------------------------------------------------------------
// wbq_fifo
// DEPTH-entry store queue. Up to NUM_CH entries are written per cycle, in
// ascending channel order; one entry is popped per cycle.
// Optional macro WBQ_FWD_EN adds a youngest-match forwarding CAM.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   enq_en_i          enqueue the flagged channels this cycle
//   enq_mask_i        per-channel enqueue flags
//   enq_addr_i/_data_i packed per-channel address/data, channel 0 in LSBs
//   enq_size_i        operand size shared by all channels
//   deq_ready_i       consumer accepts head
//   head_valid_o      queue non-empty
//   head_addr_o/_data_o/_size_o  head entry (last popped entry when empty)
//   count_o           occupied entries
//   fwd_addr_i, fwd_hit_o, fwd_data_o  (WBQ_FWD_EN only)
// -----------------------------------------------------------------------------
module wbq_fifo
    import wb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enq_en_i,
    input  logic [NUM_CH-1:0]        enq_mask_i,
    input  logic [NUM_CH*ADDR_W-1:0] enq_addr_i,
    input  logic [NUM_CH*DATA_W-1:0] enq_data_i,
    input  logic [1:0]               enq_size_i,
    input  logic                     deq_ready_i,
    output logic                     head_valid_o,
    output logic [ADDR_W-1:0]        head_addr_o,
    output logic [DATA_W-1:0]        head_data_o,
    output logic [1:0]               head_size_o,
`ifdef WBQ_FWD_EN
    input  logic [ADDR_W-1:0]        fwd_addr_i,
    output logic                     fwd_hit_o,
    output logic [DATA_W-1:0]        fwd_data_o,
`endif
    output logic [PTR_W:0]           count_o
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [1:0]        size_q [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [PTR_W-1:0]  slot_s [NUM_CH];
    logic [PTR_W:0]    n_enq_s;
    logic              deq_s;
    logic [PTR_W-1:0]  head_idx_s;

    // Slot of each enqueuing channel: write pointer plus the number of
    // lower-numbered channels that also enqueue this cycle.
    always_comb begin
        logic [PTR_W:0] run_v;
        run_v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            slot_s[i] = wr_ptr_q + run_v[PTR_W-1:0];
            if (enq_en_i && enq_mask_i[i]) begin
                run_v = run_v + (PTR_W+1)'(1);
            end else begin
                run_v = run_v;
            end
        end
        n_enq_s = run_v;
    end

    // Pointer and occupancy next-state.
    always_comb begin
        deq_s    = (count_q != '0) && deq_ready_i;
        count_d  = count_q + n_enq_s - (PTR_W+1)'(deq_s);
        wr_ptr_d = wr_ptr_q + n_enq_s[PTR_W-1:0];
        rd_ptr_d = rd_ptr_q + PTR_W'(deq_s);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; reset so the head outputs are defined straight after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
                size_q[k] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (enq_en_i && enq_mask_i[i]) begin
                    addr_q[slot_s[i]] <= enq_addr_i[i*ADDR_W +: ADDR_W];
                    data_q[slot_s[i]] <= enq_data_i[i*DATA_W +: DATA_W];
                    size_q[slot_s[i]] <= enq_size_i;
                end
            end
        end
    end

    // When empty, point one slot behind the read pointer so the head outputs
    // keep showing the entry that was popped last. That slot can only be
    // rewritten by an enqueue that also makes the queue non-empty.
    always_comb begin
        if (count_q == '0) begin
            head_idx_s = rd_ptr_q - PTR_W'(1);
        end else begin
            head_idx_s = rd_ptr_q;
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_addr_o  = addr_q[head_idx_s];
    assign head_data_o  = data_q[head_idx_s];
    assign head_size_o  = size_q[head_idx_s];
    assign count_o      = count_q;

`ifdef WBQ_FWD_EN
    // Forwarding CAM: walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_v = rd_ptr_q + PTR_W'(k);
            if (((PTR_W+1)'(k) < count_q) && (addr_q[idx_v] == fwd_addr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_q[idx_v];
            end else begin
                fwd_hit_o  = fwd_hit_o;
                fwd_data_o = fwd_data_o;
            end
        end
    end
`else
    // No forwarding path in this build.
`endif

endmodule

// File: rtl/wb_store_commit_q.sv
// -----------------------------------------------------------------------------
// wb_store_commit_q
// Writeback commit block: one retiring instruction per cycle with NUM_CH
// result channels. GPR/segment writes commit combinationally; memory results
// go through a DEPTH-entry store queue drained over a valid/ready port.
// Exceptions/interrupts wait for the queue to empty, then pulse fetch.
// Optional macro WBQ_FWD_EN adds fwd_addr/fwd_hit/fwd_data store forwarding.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   valid_in / stall         instruction present / not accepted this cycle
//   ch_data, ch_dest         per-channel result and destination, ch0 in LSBs
//   ch_is_reg/_seg/_mem      per-channel destination kind
//   size_in                  operand size shared by all channels
//   ie_in, ie_type_in        exception flag and type ([2:0] used)
//   interrupt_in             external interrupt pending
//   reg_ld, seg_ld           GPR / segment write enables
//   mem_valid/ready/addr/data/size  store queue head handshake
//   final_ie_val/_type       one-cycle event pulse, {interrupt, type[2:0]}
//   q_count                  occupied queue entries
// -----------------------------------------------------------------------------
module wb_store_commit_q
    import wb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    output logic                     stall,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH*ADDR_W-1:0] ch_dest,
    input  logic [NUM_CH-1:0]        ch_is_reg,
    input  logic [NUM_CH-1:0]        ch_is_seg,
    input  logic [NUM_CH-1:0]        ch_is_mem,
    input  logic [1:0]               size_in,
    input  logic                     ie_in,
    input  logic [3:0]               ie_type_in,
    input  logic                     interrupt_in,
    output logic [NUM_CH-1:0]        reg_ld,
    output logic [NUM_CH-1:0]        seg_ld,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data,
    output logic [1:0]               mem_size,
    output logic                     final_ie_val,
    output logic [3:0]               final_ie_type,
`ifdef WBQ_FWD_EN
    input  logic [ADDR_W-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
`endif
    output logic [PTR_W:0]           q_count
);

    wb_state_e   state_q, state_d;
    logic [3:0]  ie_type_q, ie_type_d;
    logic [7:0]  n_mem_s;
    logic [7:0]  free_s;
    logic        stall_s;
    logic        accept_s;
    logic        commit_s;
    logic        unused_s;

    assign unused_s = ie_type_in[3];

    // Stall when sequencing an event, or when the instruction's stores might
    // not fit. The pop in the same cycle is intentionally not counted.
    always_comb begin
        n_mem_s  = popcount32(32'(ch_is_mem));
        free_s   = 8'(DEPTH) - 8'(q_count);
        stall_s  = (state_q != ST_RUN) || (n_mem_s > free_s);
        accept_s = valid_in && !stall_s;
        commit_s = accept_s && !ie_in;
    end

    assign stall  = stall_s;
    assign reg_ld = ch_is_reg & {NUM_CH{commit_s}};
    assign seg_ld = ch_is_seg & {NUM_CH{commit_s}};

    wbq_fifo #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_fifo (
        .clk_i        (clk),
        .rst_i        (rst),
        .enq_en_i     (commit_s),
        .enq_mask_i   (ch_is_mem),
        .enq_addr_i   (ch_dest),
        .enq_data_i   (ch_data),
        .enq_size_i   (size_in),
        .deq_ready_i  (mem_ready),
        .head_valid_o (mem_valid),
        .head_addr_o  (mem_addr),
        .head_data_o  (mem_data),
        .head_size_o  (mem_size),
`ifdef WBQ_FWD_EN
        .fwd_addr_i   (fwd_addr),
        .fwd_hit_o    (fwd_hit),
        .fwd_data_o   (fwd_data),
`endif
        .count_o      (q_count)
    );

    // Event sequencer next-state: latch the event type on acceptance, wait for
    // the queue to empty, then spend one cycle signalling fetch.
    always_comb begin
        state_d   = state_q;
        ie_type_d = ie_type_q;
        case (state_q)
            ST_RUN: begin
                if (accept_s && (ie_in || interrupt_in)) begin
                    state_d   = ST_DRAIN;
                    ie_type_d = {interrupt_in, ie_type_in[2:0]};
                end else begin
                    state_d   = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (q_count == '0) begin
                    state_d = ST_SIGNAL;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_SIGNAL: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Event sequencer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            ie_type_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            ie_type_q <= ie_type_d;
        end
    end

    assign final_ie_val  = (state_q == ST_SIGNAL);
    assign final_ie_type = ie_type_q;

endmodule

// File: tb/tb_wb_store_commit_q.sv
module tb_wb_store_commit_q;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     valid_in;
    logic                     stall;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH*ADDR_W-1:0] ch_dest;
    logic [NUM_CH-1:0]        ch_is_reg, ch_is_seg, ch_is_mem;
    logic [1:0]               size_in;
    logic                     ie_in;
    logic [3:0]               ie_type_in;
    logic                     interrupt_in;
    logic [NUM_CH-1:0]        reg_ld, seg_ld;
    logic                     mem_valid;
    logic                     mem_ready;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_data;
    logic [1:0]               mem_size;
    logic                     final_ie_val;
    logic [3:0]               final_ie_type;
    logic [PTR_W:0]           q_count;
`ifdef WBQ_FWD_EN
    logic [ADDR_W-1:0]        fwd_addr;
    logic                     fwd_hit;
    logic [DATA_W-1:0]        fwd_data;
`endif

    always #5 clk = ~clk;

    wb_store_commit_q dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .stall         (stall),
        .ch_data       (ch_data),
        .ch_dest       (ch_dest),
        .ch_is_reg     (ch_is_reg),
        .ch_is_seg     (ch_is_seg),
        .ch_is_mem     (ch_is_mem),
        .size_in       (size_in),
        .ie_in         (ie_in),
        .ie_type_in    (ie_type_in),
        .interrupt_in  (interrupt_in),
        .reg_ld        (reg_ld),
        .seg_ld        (seg_ld),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_size      (mem_size),
        .final_ie_val  (final_ie_val),
        .final_ie_type (final_ie_type),
`ifdef WBQ_FWD_EN
        .fwd_addr      (fwd_addr),
        .fwd_hit       (fwd_hit),
        .fwd_data      (fwd_data),
`endif
        .q_count       (q_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [1:0]        size;
    } st_t;

    st_t        mq[$];
    st_t        last_st;
    st_t        new_st;
    bit         have_last;
    int         phase;       // 0 running, 1 waiting for empty queue, 2 pulsing
    logic [3:0] ev_type;
    int         m_n, m_sz;
    bit         m_stall, m_acc;
    logic [3:0] m_reg, m_seg;
`ifdef WBQ_FWD_EN
    bit                m_hit;
    logic [DATA_W-1:0] m_fdata;
`endif

    function automatic int pc(input logic [3:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) c += int'(v[i]);
        return c;
    endfunction

    // Cycle-by-cycle compare against the model, then advance the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
                phase     = 0;
                ev_type   = 4'd0;
                have_last = 1'b0;
                chk("rst_q_count", 64'(q_count), 64'd0);
                chk("rst_mem_valid", 64'(mem_valid), 64'd0);
                chk("rst_ie_val", 64'(final_ie_val), 64'd0);
            end else begin
                m_n     = pc(ch_is_mem);
                m_sz    = mq.size();
                m_stall = (phase != 0) || (m_n > DEPTH - m_sz);
                m_acc   = valid_in && !m_stall;
                m_reg   = (m_acc && !ie_in) ? ch_is_reg : 4'b0000;
                m_seg   = (m_acc && !ie_in) ? ch_is_seg : 4'b0000;
                chk("m_stall", 64'(stall), 64'(m_stall));
                chk("m_reg_ld", 64'(reg_ld), 64'(m_reg));
                chk("m_seg_ld", 64'(seg_ld), 64'(m_seg));
                chk("m_q_count", 64'(q_count), 64'(m_sz));
                chk("m_mem_valid", 64'(mem_valid), 64'(m_sz != 0));
                if (m_sz != 0) begin
                    chk("m_mem_addr", 64'(mem_addr), 64'(mq[0].addr));
                    chk("m_mem_data", mem_data, mq[0].data);
                    chk("m_mem_size", 64'(mem_size), 64'(mq[0].size));
                end else if (have_last) begin
                    chk("m_hold_addr", 64'(mem_addr), 64'(last_st.addr));
                    chk("m_hold_data", mem_data, last_st.data);
                end
                chk("m_ie_val", 64'(final_ie_val), 64'(phase == 2));
                if (phase == 2) chk("m_ie_type", 64'(final_ie_type), 64'(ev_type));
`ifdef WBQ_FWD_EN
                m_hit   = 1'b0;
                m_fdata = '0;
                foreach (mq[k]) begin
                    if (mq[k].addr == fwd_addr) begin
                        m_hit   = 1'b1;
                        m_fdata = mq[k].data;
                    end
                end
                chk("m_fwd_hit", 64'(fwd_hit), 64'(m_hit));
                if (m_hit) chk("m_fwd_data", fwd_data, m_fdata);
`endif
                // advance model to the state after the coming clock edge
                if (m_sz != 0 && mem_ready) begin
                    last_st   = mq.pop_front();
                    have_last = 1'b1;
                end
                if (m_acc && !ie_in) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_is_mem[i]) begin
                            new_st.addr = ch_dest[i*ADDR_W +: ADDR_W];
                            new_st.data = ch_data[i*DATA_W +: DATA_W];
                            new_st.size = size_in;
                            mq.push_back(new_st);
                        end
                    end
                end
                if (phase == 2) phase = 0;
                else if (phase == 1 && m_sz == 0) phase = 2;
                else if (phase == 0 && m_acc && (ie_in || interrupt_in)) begin
                    phase   = 1;
                    ev_type = {interrupt_in, ie_type_in[2:0]};
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        valid_in     = 1'b0;
        ch_data      = '0;
        ch_dest      = '0;
        ch_is_reg    = 4'b0000;
        ch_is_seg    = 4'b0000;
        ch_is_mem    = 4'b0000;
        size_in      = 2'd0;
        ie_in        = 1'b0;
        ie_type_in   = 4'd0;
        interrupt_in = 1'b0;
    endtask

    task automatic set_ch(input int i, input logic [31:0] a, input logic [63:0] d);
        ch_dest[i*ADDR_W +: ADDR_W] = a;
        ch_data[i*DATA_W +: DATA_W] = d;
    endtask

    bit found;

    initial begin
        clr();
        mem_ready = 1'b0;
`ifdef WBQ_FWD_EN
        fwd_addr = '0;
`endif
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_q_count", 64'(q_count), 64'd0);
        chk("reset_ie_type", 64'(final_ie_type), 64'd0);

        // multi-store, ordered enqueue
        tick(); clr();
        valid_in = 1'b1; ch_is_mem = 4'b0101; ch_is_reg = 4'b0010; ch_is_seg = 4'b1000;
        size_in = 2'd3;
        set_ch(0, 32'h200, 64'hAA); set_ch(2, 32'h208, 64'hBB);
        @(negedge clk);
        chk("ms_reg_ld", 64'(reg_ld), 64'h2);
        chk("ms_seg_ld", 64'(seg_ld), 64'h8);
        tick(); clr();
        @(negedge clk);
        chk("ms_q_count", 64'(q_count), 64'd2);
        chk("ms_head0", mem_data, 64'hAA);
        chk("ms_addr0", 64'(mem_addr), 64'h200);
        chk("ms_size0", 64'(mem_size), 64'd3);
        tick(); mem_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("ms_head1", mem_data, 64'hBB);
        chk("ms_q_count1", 64'(q_count), 64'd1);
        tick(); mem_ready = 1'b0;
        @(negedge clk);
        chk("ms_empty", 64'(mem_valid), 64'd0);
        chk("ms_hold", mem_data, 64'hBB);

        // full / stall
        tick(); clr();
        valid_in = 1'b1; ch_is_mem = 4'b0111;
        set_ch(0, 32'h300, 64'h11); set_ch(1, 32'h304, 64'h22); set_ch(2, 32'h308, 64'h33);
        tick(); clr();
        valid_in = 1'b1; ch_is_mem = 4'b0011; ch_is_reg = 4'b0001;
        set_ch(0, 32'h400, 64'h44); set_ch(1, 32'h404, 64'h55);
        @(negedge clk);
        chk("full_q_count", 64'(q_count), 64'd3);
        chk("full_stall", 64'(stall), 64'd1);
        chk("full_reg_ld", 64'(reg_ld), 64'd0);
        tick(); mem_ready = 1'b1;
        @(negedge clk);
        chk("full_stall_pop", 64'(stall), 64'd1);
        tick(); mem_ready = 1'b0;
        @(negedge clk);
        chk("full_accept", 64'(stall), 64'd0);
        chk("full_accept_reg", 64'(reg_ld), 64'd1);
        tick(); clr(); mem_ready = 1'b1;
        @(negedge clk);
        chk("full_q4", 64'(q_count), 64'd4);
        chk("full_head", mem_data, 64'h22);
        repeat (4) tick();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("full_drained", 64'(q_count), 64'd0);
        chk("full_hold", mem_data, 64'h55);

        // simultaneous enqueue and dequeue
        tick(); clr();
        valid_in = 1'b1; ch_is_mem = 4'b0011;
        set_ch(0, 32'h500, 64'h61); set_ch(1, 32'h504, 64'h62);
        tick(); clr();
        valid_in = 1'b1; ch_is_mem = 4'b0011; mem_ready = 1'b1;
        set_ch(0, 32'h508, 64'h63); set_ch(1, 32'h50C, 64'h64);
        @(negedge clk);
        chk("sim_stall", 64'(stall), 64'd0);
        tick(); clr(); mem_ready = 1'b0;
        @(negedge clk);
        chk("sim_q_count", 64'(q_count), 64'd3);
        chk("sim_head", mem_data, 64'h62);
        tick(); mem_ready = 1'b1;
        repeat (3) tick();
        mem_ready = 1'b0;

        // exact fill, no-flag retire, one-too-many
        tick(); clr();
        valid_in = 1'b1; ch_is_mem = 4'b1111;
        for (int i = 0; i < 4; i++) set_ch(i, 32'h800 + 32'(i * 8), 64'h71 + 64'(i));
        @(negedge clk);
        chk("fill_stall", 64'(stall), 64'd0);
        tick(); clr(); valid_in = 1'b1;
        @(negedge clk);
        chk("fill_q4", 64'(q_count), 64'd4);
        chk("noflag_stall", 64'(stall), 64'd0);
        tick(); clr(); valid_in = 1'b1; ch_is_mem = 4'b0001;
        @(negedge clk);
        chk("over_stall", 64'(stall), 64'd1);
        tick(); clr(); mem_ready = 1'b1;
        repeat (4) tick();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("fill_drained", 64'(q_count), 64'd0);

        // exception drain
        tick(); clr();
        valid_in = 1'b1; ch_is_mem = 4'b0011;
        set_ch(0, 32'h600, 64'h81); set_ch(1, 32'h604, 64'h82);
        tick(); clr();
        valid_in = 1'b1; ie_in = 1'b1; ie_type_in = 4'h5;
        ch_is_reg = 4'b1111; ch_is_seg = 4'b0001; ch_is_mem = 4'b0001;
        set_ch(0, 32'h700, 64'h99);
        @(negedge clk);
        chk("exc_reg_ld", 64'(reg_ld), 64'd0);
        chk("exc_seg_ld", 64'(seg_ld), 64'd0);
        chk("exc_accept", 64'(stall), 64'd0);
        tick(); clr();
        @(negedge clk);
        chk("exc_stall", 64'(stall), 64'd1);
        chk("exc_q_count", 64'(q_count), 64'd2);
        tick(); valid_in = 1'b1; ch_is_reg = 4'b0001; mem_ready = 1'b1;
        @(negedge clk);
        chk("exc_hold_stall", 64'(stall), 64'd1);
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            tick();
            @(negedge clk);
            if (final_ie_val) found = 1'b1;
        end
        chk("exc_pulse_seen", 64'(found), 64'd1);
        chk("exc_type", 64'(final_ie_type), 64'h5);
        chk("exc_q_empty", 64'(q_count), 64'd0);
        tick();
        @(negedge clk);
        chk("exc_pulse_end", 64'(final_ie_val), 64'd0);
        chk("exc_run", 64'(stall), 64'd0);
        tick(); clr(); mem_ready = 1'b0;

        // interrupt on an empty queue
        tick(); clr();
        valid_in = 1'b1; interrupt_in = 1'b1; ch_is_reg = 4'b0001;
        @(negedge clk);
        chk("irq_reg_ld", 64'(reg_ld), 64'd1);
        tick(); clr();
        @(negedge clk);
        chk("irq_t1_val", 64'(final_ie_val), 64'd0);
        chk("irq_t1_stall", 64'(stall), 64'd1);
        tick();
        @(negedge clk);
        chk("irq_t2_val", 64'(final_ie_val), 64'd1);
        chk("irq_t2_type", 64'(final_ie_type), 64'h8);
        tick();
        @(negedge clk);
        chk("irq_t3_val", 64'(final_ie_val), 64'd0);
        chk("irq_t3_stall", 64'(stall), 64'd0);

`ifdef WBQ_FWD_EN
        // store forwarding: youngest match wins
        tick(); clr();
        valid_in = 1'b1; ch_is_mem = 4'b0001; set_ch(0, 32'h100, 64'h1);
        tick(); set_ch(0, 32'h100, 64'h2);
        tick(); clr(); fwd_addr = 32'h100;
        @(negedge clk);
        chk("fwd_hit", 64'(fwd_hit), 64'd1);
        chk("fwd_data", fwd_data, 64'h2);
        tick(); fwd_addr = 32'h104;
        @(negedge clk);
        chk("fwd_miss", 64'(fwd_hit), 64'd0);
        tick(); mem_ready = 1'b1;
        repeat (3) tick();
        mem_ready = 1'b0;
`endif

        // reset in the middle of a drain
        tick(); clr();
        valid_in = 1'b1; ch_is_mem = 4'b0111;
        set_ch(0, 32'h900, 64'hA1); set_ch(1, 32'h904, 64'hA2); set_ch(2, 32'h908, 64'hA3);
        tick(); clr();
        valid_in = 1'b1; ie_in = 1'b1; ie_type_in = 4'h3;
        @(negedge clk);
        chk("rmid_q3", 64'(q_count), 64'd3);
        tick(); clr();
        @(negedge clk);
        chk("rmid_drain", 64'(stall), 64'd1);
        tick(); rst = 1'b1;
        @(negedge clk);
        chk("rmid_q0", 64'(q_count), 64'd0);
        chk("rmid_mv", 64'(mem_valid), 64'd0);
        tick(); rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rmid_no_pulse", 64'(final_ie_val), 64'd0);
            tick();
        end
        @(negedge clk);
        chk("rmid_run", 64'(stall), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
